seq_mul_arbiter: RTL and testbench
==================================

# seq_mul_arbiter

Round-robin arbiter and sequencer that shares one sequential multiplier among NREQ requesters. It accepts one operand pair at a time over a valid/ready handshake and pulses the multiplier's start input. It waits for the multiplier's completion pulse, then returns the product to the granted requester over a valid/ready response channel. It sits between the client blocks and the existing sequential multiplier (datapath plus controller) and is the only block that drives that multiplier's start and operand inputs.

## Interface
Reset is synchronous and active-high. One clock domain.

Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 16, operand width; product is 2*WIDTH

Ports:
- CLK  input  1  clock, rising edge
- RST  input  1  synchronous, active-high reset
- req_valid  input  NREQ  per-requester operand valid
- req_a  input  NREQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH]
- req_b  input  NREQ*WIDTH  operand B, same packing
- req_ready  output  NREQ  one-hot accept strobe
- resp_valid  output  NREQ  one-hot product valid
- resp_product  output  2*WIDTH  product, shared by all requesters, qualified by resp_valid
- resp_ready  input  NREQ  per-requester response accept
- mul_start  output  1  one-cycle start pulse to the multiplier
- mul_a  output  WIDTH  multiplicand to the multiplier
- mul_b  output  WIDTH  multiplier operand to the multiplier
- mul_ready  input  1  multiplier done pulse (READYO)
- mul_product  input  2*WIDTH  multiplier result, valid in the mul_ready cycle
- busy  output  1  high in every state except IDLE
- grant_id  output  $clog2(NREQ)  index of the current or last grant

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - The grant goes to the first i with req_valid[i]=1, searching from rr_ptr upward with wrap modulo NREQ.
  - req_ready[grant] is driven combinationally high in the same cycle.
  - On that edge: latch req_a/req_b of the grant into the operand registers, latch grant_id, go to ISSUE.
  - With no req_valid, stay in IDLE.
- **ISSUE**: mul_start=1 for exactly one cycle; mul_a/mul_b show the latched operands; go to WAIT.
- **WAIT**
  - mul_a/mul_b are held stable.
  - When mul_ready=1, capture mul_product into the product register and go to RESP.
- **RESP**
  - resp_valid[grant_id]=1 and resp_product shows the product register.
  - When resp_ready[grant_id]=1: rr_ptr <= (grant_id+1) mod NREQ, go to IDLE.
- **Pass-through rules**
  - No arithmetic is done in this block; operands and product pass through unchanged.
  - Signedness is defined by the multiplier.
- **Requester rules**
  - A requester holds req_valid and its operands until it sees req_ready.
  - req_valid that drops before grant is not an error; that requester is simply skipped.
- **Ignored inputs**
  - mul_ready outside WAIT is ignored.
  - resp_ready bits other than grant_id are ignored.
- **Reset values** (all outputs return to these on RST=1 in any state, mid-transaction included):
  - State IDLE, rr_ptr=0, grant_id=0.
  - req_ready=0, resp_valid=0, mul_start=0, busy=0.
  - mul_a=0, mul_b=0, resp_product=0.
- **Shared reset**: the multiplier shares RST, so no operation survives reset.

## Timing
- **Accept**: the accept handshake completes on edge T, when req_valid[i] & req_ready[i] are both high.
  - mul_start is high in cycle T+1.
  - The multiplier sees operands from T+1 until mul_ready.
- **Total latency** from accept to resp_valid = 2 + multiplier latency.
  - Arbiter overhead is 1 cycle in ISSUE.
  - There is 1 cycle from the mul_ready cycle to the first RESP cycle.
- **Turnaround**: one IDLE cycle minimum between resp handshake and the next accept. Throughput is one operation per (multiplier latency + 3 + response stall) cycles.
- **Signal behaviour by state**
  - req_ready is only ever high in IDLE and never on more than one bit.
  - resp_valid is only high in RESP and stays asserted, with resp_product stable, until accepted.
- **Response stall**: other requesters remain pending and are not accepted while a response is stalled (single outstanding op).
- **Pointer fairness**: the pointer advances only after the response completes, so a requester that has been served has lowest priority next.
- **Wrap-around**: grant search and rr_ptr wrap from NREQ-1 to 0.

## Test plan
- **Reset**: RST high 2 cycles mid-WAIT -> next cycle busy=0, mul_start=0, resp_valid=0, rr_ptr=0. A stale mul_ready afterward produces no response.
- **Single request**: req_valid[2]=1, a=16'd3, b=16'd7 -> req_ready[2] 1 cycle, mul_start next cycle with mul_a=3/mul_b=7, resp_valid[2] with resp_product=32'd21 after mul_ready.
- **Round-robin**: all four req_valid held high -> grants in order 0,1,2,3,0, with each resp completed before the next req_ready.
- **Wrap-around**: after grant 3, only req_valid[1] and [3] high -> grant 1 next, not 3.
- **Response stall**: resp_ready[0]=0 for 10 cycles -> resp_valid[0] and resp_product stay stable, no req_ready to others. Raising resp_ready[0] -> IDLE the next cycle.
- **Spurious done**: mul_ready pulsed in IDLE/ISSUE -> ignored, no state change, no resp_valid; the correct product is still returned on the real pulse.

Source files
------------

// File: rtl/seq_mul_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | seq_mul_arbiter                                                        |
// | Round-robin front end that shares one sequential multiplier.           |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module seq_mul_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [NREQ-1:0]             req_valid,
  input  logic [NREQ*WIDTH-1:0]       req_a,
  input  logic [NREQ*WIDTH-1:0]       req_b,
  output logic [NREQ-1:0]             req_ready,
  output logic [NREQ-1:0]             resp_valid,
  output logic [2*WIDTH-1:0]          resp_product,
  input  logic [NREQ-1:0]             resp_ready,
  output logic                        mul_start,
  output logic [WIDTH-1:0]            mul_a,
  output logic [WIDTH-1:0]            mul_b,
  input  logic                        mul_ready,
  input  logic [2*WIDTH-1:0]          mul_product,
  output logic                        busy,
  output logic [$clog2(NREQ)-1:0]     grant_id
);

  localparam int IDW = $clog2(NREQ);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]     grant_id_q, grant_id_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;

  logic               found;
  logic [IDW-1:0]     sel;

  // First pending requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    logic [IDW-1:0] cand;
    cand  = '0;
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDW'((int'(rr_ptr_q) + k) % NREQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    a_d        = a_q;
    b_d        = b_q;
    prod_d     = prod_q;
    req_ready  = '0;
    resp_valid = '0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          req_ready[sel] = 1'b1;
          grant_id_d     = sel;
          a_d            = req_a[int'(sel)*WIDTH +: WIDTH];
          b_d            = req_b[int'(sel)*WIDTH +: WIDTH];
          state_d        = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (mul_ready) begin
          prod_d  = mul_product;
          state_d = S_RESP;
        end
      end
      default: begin
        resp_valid[grant_id_q] = 1'b1;
        // Pointer moves only once the response is taken, so the served requester drops to lowest priority.
        if (resp_ready[grant_id_q]) begin
          rr_ptr_d = (grant_id_q == IDW'(NREQ-1)) ? '0 : grant_id_q + IDW'(1);
          state_d  = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      a_q        <= '0;
      b_q        <= '0;
      prod_q     <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      a_q        <= a_d;
      b_q        <= b_d;
      prod_q     <= prod_d;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign mul_start    = (state_q == S_ISSUE);
  assign mul_a        = a_q;
  assign mul_b        = b_q;
  assign resp_product = prod_q;
  assign grant_id     = grant_id_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_mul_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_seq_mul_arbiter                                                     |
// | Self-checking bench with a behavioural multiplier and scoreboard.      |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_seq_mul_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 16;
  localparam int MLAT  = 3;

  logic                    CLK = 1'b0;
  logic                    RST;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ*WIDTH-1:0]   req_a, req_b;
  logic [NREQ-1:0]         req_ready, resp_valid, resp_ready;
  logic [2*WIDTH-1:0]      resp_product, mul_product;
  logic                    mul_start, mul_ready, busy;
  logic [WIDTH-1:0]        mul_a, mul_b;
  logic [1:0]              grant_id;

  seq_mul_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_product(resp_product),
    .resp_ready(resp_ready), .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_ready(mul_ready), .mul_product(mul_product), .busy(busy), .grant_id(grant_id)
  );

  always #5 CLK = ~CLK;

  // Behavioural multiplier: done pulse MLAT cycles after the start cycle.
  logic        m_rdy = 1'b0, spur_rdy = 1'b0;
  logic [31:0] mprod = '0;
  logic [15:0] ma, mb;
  bit          mpend = 1'b0;
  int          mcnt;
  assign mul_ready   = m_rdy | spur_rdy;
  assign mul_product = m_rdy ? mprod : 32'hDEAD_BEEF;

  initial forever begin
    @(posedge CLK); #1;
    m_rdy = 1'b0;
    if (RST) mpend = 1'b0;
    else if (mpend) begin
      if (mcnt == 1) begin
        m_rdy = 1'b1;
        mprod = {16'b0, ma} * {16'b0, mb};
        mpend = 1'b0;
      end else mcnt--;
    end else if (mul_start) begin
      mpend = 1'b1; mcnt = MLAT; ma = mul_a; mb = mul_b;
    end
  end

  int nvec = 0, nfail = 0;
  typedef struct { int id; logic [31:0] prod; } sb_t;
  sb_t sbq[$];
  logic [15:0] opa[NREQ], opb[NREQ];

  typedef struct { int id; logic [15:0] a; logic [15:0] b; logic [31:0] prod; } vec_t;
  vec_t tbl[5];

  task automatic tick(); @(posedge CLK); #2; endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_ops();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*WIDTH +: WIDTH] = opa[i];
      req_b[i*WIDTH +: WIDTH] = opb[i];
    end
  endtask

  task automatic wait_grant(output int gid);
    gid = -1;
    #1;
    for (int c = 0; c < 20 && gid < 0; c++) begin
      if (req_ready != '0) begin
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) gid = i;
        chk("req_ready_onehot", {60'b0, req_ready}, 64'(1) << gid);
      end else tick();
    end
    if (gid < 0) chk("grant_timeout", 0, 1);
  endtask

  // Handshake edge for gid, then check the ISSUE cycle.
  task automatic accept(input int gid, input bit drop, input logic [31:0] exp);
    sb_t e;
    logic [15:0] ea, eb;
    ea = opa[gid]; eb = opb[gid];
    e.id = gid; e.prod = exp;
    sbq.push_back(e);
    tick();
    if (drop) req_valid[gid] = 1'b0;
    chk("issue_start", {63'b0, mul_start}, 64'd1);
    chk("issue_mul_a", {48'b0, mul_a}, {48'b0, ea});
    chk("issue_mul_b", {48'b0, mul_b}, {48'b0, eb});
    chk("issue_grant_id", {62'b0, grant_id}, 64'(gid));
  endtask

  task automatic finish_resp(input int stall);
    sb_t e;
    int c;
    c = 0;
    while (resp_valid == '0 && c < 50) begin tick(); c++; end
    if (resp_valid == '0 || sbq.size() == 0) begin
      chk("resp_timeout", 0, 1);
      return;
    end
    e = sbq.pop_front();
    chk("resp_valid", {60'b0, resp_valid}, 64'(1) << e.id);
    chk("resp_product", {32'b0, resp_product}, {32'b0, e.prod});
    resp_ready = ~(4'(1) << e.id);
    for (int s = 0; s < stall; s++) begin
      tick();
      chk("stall_resp_valid", {60'b0, resp_valid}, 64'(1) << e.id);
      chk("stall_product", {32'b0, resp_product}, {32'b0, e.prod});
      chk("stall_req_ready", {60'b0, req_ready}, 64'd0);
    end
    resp_ready = 4'(1) << e.id;
    tick();
    resp_ready = '0;
    chk("post_resp_busy", {63'b0, busy}, 64'd0);
    chk("post_resp_valid", {60'b0, resp_valid}, 64'd0);
  endtask

  task automatic check_reset_state();
    chk("rst_busy", {63'b0, busy}, 0);
    chk("rst_mul_start", {63'b0, mul_start}, 0);
    chk("rst_resp_valid", {60'b0, resp_valid}, 0);
    chk("rst_mul_a", {48'b0, mul_a}, 0);
    chk("rst_mul_b", {48'b0, mul_b}, 0);
    chk("rst_product", {32'b0, resp_product}, 0);
    chk("rst_grant_id", {62'b0, grant_id}, 0);
  endtask

  task automatic do_reset();
    RST = 1'b1; tick(); tick(); RST = 1'b0;
    sbq.delete();
  endtask

  initial begin
    int g;
    tbl[0] = '{2, 16'd3,      16'd7,      32'd21};
    tbl[1] = '{0, 16'hFFFF,   16'hFFFF,   32'hFFFE_0001};
    tbl[2] = '{1, 16'hABCD,   16'h0000,   32'd0};
    tbl[3] = '{3, 16'h8000,   16'd2,      32'h0001_0000};
    tbl[4] = '{0, 16'd1234,   16'd5678,   32'd7006652};

    RST = 1'b1; req_valid = '0; resp_ready = '0; req_a = '0; req_b = '0;
    for (int i = 0; i < NREQ; i++) begin opa[i] = '0; opb[i] = '0; end
    tick(); tick();
    check_reset_state();
    chk("rst_req_ready", {60'b0, req_ready}, 0);
    RST = 1'b0;
    tick();

    // Single requests from the vector table
    for (int v = 0; v < 5; v++) begin
      opa[tbl[v].id] = tbl[v].a; opb[tbl[v].id] = tbl[v].b; drive_ops();
      req_valid[tbl[v].id] = 1'b1;
      wait_grant(g);
      chk("tbl_grant", 64'(g), 64'(tbl[v].id));
      if (g >= 0) begin accept(g, 1'b1, tbl[v].prod); finish_resp(0); end
      req_valid = '0;
    end

    // Round-robin with all requesters continuously pending
    do_reset();
    for (int i = 0; i < NREQ; i++) begin opa[i] = 16'(100 + i); opb[i] = 16'(3 + 2*i); end
    drive_ops(); req_valid = '1;
    for (int r = 0; r < 5; r++) begin
      wait_grant(g);
      chk("rr_order", 64'(g), 64'(r % NREQ));
      if (g < 0) break;
      accept(g, 1'b0, {16'b0, opa[g]} * {16'b0, opb[g]});
      opa[g] = opa[g] + 16'd50; opb[g] = opb[g] + 16'd1; drive_ops();
      finish_resp(0);
    end
    req_valid = '0;

    // Wrap-around: after grant 3 the pointer is 0, so 1 beats 3
    do_reset();
    opa[3] = 16'd5; opb[3] = 16'd6; opa[1] = 16'd40; opb[1] = 16'd41; drive_ops();
    req_valid = 4'b1000;
    wait_grant(g); chk("wrap_first", 64'(g), 64'd3);
    if (g >= 0) begin accept(g, 1'b1, 32'd30); finish_resp(0); end
    opa[3] = 16'd7; drive_ops();
    req_valid = 4'b1010;
    wait_grant(g); chk("wrap_second", 64'(g), 64'd1);
    if (g >= 0) begin accept(g, 1'b1, 32'd1640); finish_resp(0); end
    wait_grant(g); chk("wrap_third", 64'(g), 64'd3);
    if (g >= 0) begin accept(g, 1'b1, 32'd42); finish_resp(0); end
    req_valid = '0;

    // Response stall with other requesters pending
    do_reset();
    opa[0] = 16'd250; opb[0] = 16'd4; opa[1] = 16'd1; opb[1] = 16'd1; opa[2] = 16'd2; opb[2] = 16'd2;
    drive_ops(); req_valid = 4'b0111;
    wait_grant(g); chk("stall_grant", 64'(g), 64'd0);
    if (g >= 0) begin accept(g, 1'b1, 32'd1000); finish_resp(10); end
    #1 chk("stall_next_grant", {60'b0, req_ready}, 64'b0010);
    req_valid = '0;
    tick();
    chk("dropped_idle", {63'b0, busy}, 0);

    // Spurious done pulses in IDLE and ISSUE
    spur_rdy = 1'b1; tick(); spur_rdy = 1'b0;
    chk("spur_idle_busy", {63'b0, busy}, 0);
    chk("spur_idle_resp", {60'b0, resp_valid}, 0);
    opa[1] = 16'd9; opb[1] = 16'd11; drive_ops(); req_valid[1] = 1'b1;
    wait_grant(g); chk("spur_grant", 64'(g), 64'd1);
    if (g >= 0) begin
      accept(g, 1'b1, 32'd99);
      spur_rdy = 1'b1; tick(); spur_rdy = 1'b0;
      chk("spur_issue_wait", {62'b0, busy, mul_start}, 64'b10);
      chk("spur_issue_resp", {60'b0, resp_valid}, 0);
      finish_resp(0);
    end

    // Reset in the middle of WAIT, then a stale done pulse
    opa[2] = 16'd77; opb[2] = 16'd88; drive_ops(); req_valid[2] = 1'b1;
    wait_grant(g);
    if (g >= 0) accept(g, 1'b1, 32'd6776);
    tick();
    do_reset();
    check_reset_state();
    spur_rdy = 1'b1; tick(); spur_rdy = 1'b0;
    tick(); tick(); tick(); tick(); tick();
    chk("stale_resp", {60'b0, resp_valid}, 0);
    chk("stale_busy", {63'b0, busy}, 0);
    for (int i = 0; i < NREQ; i++) begin opa[i] = 16'(i + 1); opb[i] = 16'd10; end
    drive_ops(); req_valid = '1;
    wait_grant(g); chk("rr_after_reset", 64'(g), 64'd0);
    if (g >= 0) begin accept(g, 1'b1, 32'd10); finish_resp(0); end
    req_valid = '0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
`default_nettype wire
